// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache: direct-mapped, one-word-per-line instruction cache.
//
// A request made with icache_en_i is answered by a single icache_rvalid_o pulse.
// A hit answers in the cycle after the request. A miss issues one word read to
// the backing memory, fills the line and then answers. A newer request replaces
// the one in flight. A replaced miss still fills its line but gives no response.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   icache_en_i       request strobe (sampled every posedge)
//   icache_addr_i     request byte address (bits [1:0] ignored)
//   icache_rdata_o    instruction word, 0 unless icache_rvalid_o
//   icache_rvalid_o   one-cycle response pulse
//   inv_i             invalidate all lines
//   mem_req_o         memory read request, held until mem_rvalid_i
//   mem_addr_o        word-aligned memory read address, 0 when idle
//   mem_rdata_i       memory read data
//   mem_rvalid_i      memory read data valid
// -----------------------------------------------------------------------------
module icache #(
    parameter int IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_en_i,
    input  logic [31:0] icache_addr_i,
    output logic [31:0] icache_rdata_o,
    output logic        icache_rvalid_o,
    input  logic        inv_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rvalid_i
);

    localparam int LINES = 1 << IDX_BITS;
    localparam int TAG_W = 30 - IDX_BITS;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MISS   = 3'd2,
        S_RESP   = 3'd3,
        S_REPLAY = 3'd4
    } state_t;

    state_t               state_r;
    logic [31:2]          req_addr_r;
    logic [31:2]          pend_addr_r;
    logic                 drop_r;
    logic [31:0]          fill_r;
    logic                 mem_req_r;
    logic [31:0]          mem_addr_r;
    logic [LINES-1:0]     valid_r;

    logic [31:0]          data_mem [LINES];
    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [31:0]          rd_data_r;
    logic [TAG_W-1:0]     rd_tag_r;

    logic [IDX_BITS-1:0]  req_idx_s;
    logic [TAG_W-1:0]     req_tag_s;
    logic                 hit_s;
    logic                 rd_en_s;
    logic [IDX_BITS-1:0]  rd_idx_s;
    logic                 wr_en_s;
    logic                 unused_s;

    // Byte-offset bits carry no information for a word-wide cache.
    assign unused_s  = ^icache_addr_i[1:0];

    assign req_idx_s = req_addr_r[IDX_BITS+1:2];
    assign req_tag_s = req_addr_r[31:IDX_BITS+2];

    // Valid bits are read as they stand this cycle, so an inv_i in the same
    // cycle does not affect the compare.
    assign hit_s     = valid_r[req_idx_s] && (rd_tag_r == req_tag_s);

    // A fill happens only in MISS. A fill is never written in the cycle
    // that reset is applied.
    assign wr_en_s   = (state_r == S_MISS) && mem_rvalid_i && !rst;

    // Select the array read port: a new request reads at its own index.
    // REPLAY reads at the stored request unless a newer one arrives.
    always_comb begin
        rd_en_s  = 1'b0;
        rd_idx_s = req_idx_s;
        case (state_r)
            S_IDLE, S_LOOKUP, S_RESP: begin
                rd_en_s  = icache_en_i;
                rd_idx_s = icache_addr_i[IDX_BITS+1:2];
            end
            S_REPLAY: begin
                rd_en_s = 1'b1;
                if (icache_en_i) begin
                    rd_idx_s = icache_addr_i[IDX_BITS+1:2];
                end else begin
                    rd_idx_s = req_idx_s;
                end
            end
            default: begin
                rd_en_s  = 1'b0;
                rd_idx_s = req_idx_s;
            end
        endcase
    end

    // Data/tag storage: synchronous-read RAMs without reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            data_mem[req_idx_s] <= mem_rdata_i;
            tag_mem[req_idx_s]  <= req_tag_s;
        end
        if (rd_en_s) begin
            rd_data_r <= data_mem[rd_idx_s];
            rd_tag_r  <= tag_mem[rd_idx_s];
        end
    end

    // Control FSM with request/pending registers, valid bits and memory port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            req_addr_r  <= 30'd0;
            pend_addr_r <= 30'd0;
            drop_r      <= 1'b0;
            fill_r      <= 32'd0;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= 32'd0;
            valid_r     <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (icache_en_i) begin
                        req_addr_r <= icache_addr_i[31:2];
                        state_r    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (icache_en_i) begin
                        // The new request replaces the old one. A miss on the
                        // old request is not fetched.
                        req_addr_r <= icache_addr_i[31:2];
                        state_r    <= S_LOOKUP;
                    end else if (hit_s) begin
                        state_r <= S_IDLE;
                    end else begin
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= {req_addr_r, 2'b00};
                        drop_r     <= 1'b0;
                        state_r    <= S_MISS;
                    end
                end
                S_MISS: begin
                    if (icache_en_i) begin
                        pend_addr_r <= icache_addr_i[31:2];
                        drop_r      <= 1'b1;
                    end
                    if (mem_rvalid_i) begin
                        valid_r[req_idx_s] <= 1'b1;
                        fill_r             <= mem_rdata_i;
                        mem_req_r          <= 1'b0;
                        mem_addr_r         <= 32'd0;
                        drop_r             <= 1'b0;
                        if (drop_r || icache_en_i) begin
                            req_addr_r <= icache_en_i ? icache_addr_i[31:2] : pend_addr_r;
                            state_r    <= S_REPLAY;
                        end else begin
                            state_r <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (icache_en_i) begin
                        req_addr_r <= icache_addr_i[31:2];
                        state_r    <= S_LOOKUP;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_REPLAY: begin
                    if (icache_en_i) begin
                        req_addr_r <= icache_addr_i[31:2];
                    end
                    state_r <= S_LOOKUP;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
            // Invalidate wins over a fill that completes in the same cycle.
            if (inv_i) begin
                valid_r <= '0;
            end
        end
    end

    // Response decode. It uses only registered state and the registered RAM output.
    always_comb begin
        icache_rvalid_o = 1'b0;
        icache_rdata_o  = 32'd0;
        case (state_r)
            S_LOOKUP: begin
                if (hit_s) begin
                    icache_rvalid_o = 1'b1;
                    icache_rdata_o  = rd_data_r;
                end else begin
                    icache_rvalid_o = 1'b0;
                    icache_rdata_o  = 32'd0;
                end
            end
            S_RESP: begin
                icache_rvalid_o = 1'b1;
                icache_rdata_o  = fill_r;
            end
            default: begin
                icache_rvalid_o = 1'b0;
                icache_rdata_o  = 32'd0;
            end
        endcase
    end

    assign mem_req_o  = mem_req_r;
    assign mem_addr_o = mem_addr_r;

endmodule
